// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder/subtractor.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nine's complement of one decimal digit; non-BCD inputs map to 10..15 again.
    function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] digit);
        return DIGIT_W'(BCD_MAX) - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with BCD correction and invalid-digit detect.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               c,
    output logic [DIGIT_W-1:0] s_d,
    output logic               c_o,
    output logic               inv
);

    localparam int unsigned SUM_W = DIGIT_W + 1;

    logic [SUM_W-1:0] t;

    // Binary digit sum, then +6 correction when the decimal digit overflows.
    always_comb begin
        t   = {1'b0, a_d} + {1'b0, b_d} + SUM_W'(c);
        s_d = t[DIGIT_W-1:0];
        c_o = 1'b0;
        if (t > SUM_W'(BCD_MAX)) begin
            s_d = DIGIT_W'(t + SUM_W'(BCD_CORR));
            c_o = 1'b1;
        end
        inv = (a_d > DIGIT_W'(BCD_MAX)) || (b_d > DIGIT_W'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional build macro BCD_DIGIT_CHECK_EN adds the sticky invalid-digit flag 'err'.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*NDIG-1:0] sum,
    output logic                    cout,
    output logic                    busy
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int unsigned DATA_W   = DIGIT_W * NDIG;
    localparam int unsigned IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned LAST_IDX = NDIG - 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic                sub_q, sub_d;
    logic                carry_q, carry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [DIGIT_W-1:0]  dig_a;
    logic [DIGIT_W-1:0]  dig_b_raw;
    logic [DIGIT_W-1:0]  dig_b;
    logic [DIGIT_W-1:0]  dig_s;
    logic                dig_c;
    logic                last_digit;

`ifdef BCD_DIGIT_CHECK_EN
    logic                digit_inv;
    logic                err_sticky_q, err_sticky_d;
    logic                err_q, err_d;
`else
    logic                unused_digit_inv;
`endif

    // Operand digit selection; subtraction adds the nine's complement of B.
    always_comb begin
        dig_a      = opa_q[DIGIT_W*idx_q +: DIGIT_W];
        dig_b_raw  = opb_q[DIGIT_W*idx_q +: DIGIT_W];
        dig_b      = sub_q ? nines_comp(dig_b_raw) : dig_b_raw;
        last_digit = (idx_q == IDX_W'(LAST_IDX));
    end

    // The complement keeps 10..15 out of the BCD range, so inv still flags bad B digits.
    bcd_digit_add u_digit_add (
        .a_d (dig_a),
        .b_d (dig_b),
        .c   (carry_q),
        .s_d (dig_s),
        .c_o (dig_c),
`ifdef BCD_DIGIT_CHECK_EN
        .inv (digit_inv)
`else
        .inv (unused_digit_inv)
`endif
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Handshake/status flags decoded from the next state so they come out of flops.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    // Operand capture and digit-serial accumulation.
    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_sticky_d = err_sticky_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
`ifdef BCD_DIGIT_CHECK_EN
                    err_sticky_d = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d[DIGIT_W*idx_q +: DIGIT_W] = dig_s;
                carry_d = dig_c;
                idx_d   = idx_q + IDX_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
                err_sticky_d = err_sticky_q | digit_inv;
`endif
                if (last_digit) begin
                    cout_d = dig_c;
                    idx_d  = '0;
                end
            end
            default: ;
        endcase
`ifdef BCD_DIGIT_CHECK_EN
        err_d = (state_d == DONE) && err_sticky_d;
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q       <= '0;
            opb_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_sticky_q <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_sticky_q <= err_sticky_d;
            err_q        <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: integer-arithmetic reference model,
// directed vectors with literal expectations, backpressure, mid-run reset, random ops.
module tb_bcd_serial_adder;

    localparam int unsigned NDIG = 4;
    localparam int unsigned W    = 4 * NDIG;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef BCD_DIGIT_CHECK_EN
    logic         err;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        logic         defined;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    int     bp_mode = 0;
    logic   or_force = 1'b0;
    logic   prev_ov = 1'b0;

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef BCD_DIGIT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        longint p = 1;
        for (int i = 0; i < NDIG; i++) begin
            r = r + longint'(v[i*4 +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint       x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal reference: operate on integers, convert back to packed BCD.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint ax = bcd2int(x);
        longint by = bcd2int(y);
        longint m  = pow10(NDIG);
        longint t;
        e.err = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) e.err = 1'b1;
        end
        e.defined = !e.err;
        if (sb) begin
            if (ax >= by) begin
                e.sum  = int2bcd(ax - by);
                e.cout = 1'b1;
            end else begin
                e.sum  = int2bcd(m - (by - ax));
                e.cout = 1'b0;
            end
        end else begin
            t      = ax + by + (ci ? 1 : 0);
            e.cout = (t >= m);
            e.sum  = int2bcd(t % m);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Consumer side: random or forced backpressure, changed just after the edge.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = or_force;
        endcase
    end

    // Compare process: every DONE cycle against the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc - acc_cyc), 64'(NDIG + 1));
                    if (exp_q[0].defined) begin
                        chk("sum", 64'(sum), 64'(exp_q[0].sum));
                        chk("cout", 64'(cout), 64'(exp_q[0].cout));
                    end
`ifdef BCD_DIGIT_CHECK_EN
                    chk("err", 64'(err), 64'(exp_q[0].err));
`endif
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                    chk("busy_in_done", 64'(busy), 64'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
        int n = 0;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(x, y, ci, sb));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic sb,
                            input logic [W-1:0] es, input logic ec);
        exp_t e = model(x, y, ci, sb);
        chk({name, "_model_sum"}, 64'(e.sum), 64'(es));
        chk({name, "_model_cout"}, 64'(e.cout), 64'(ec));
        send(x, y, ci, sb);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        directed("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0);
        directed("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        directed("add_0999_cin",  16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);
        directed("add_max_cin",   16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1);
        directed("sub_5000_1234", 16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1);
        directed("sub_1234_5000", 16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0);
        directed("sub_eq_cin",    16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1);
        directed("sub_0_1",       16'h0000, 16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0);

        // Backpressure: result held for 10 cycles, then a one-cycle ready pulse.
        bp_mode = 2; or_force = 1'b0;
        e = model(16'h0042, 16'h0058, 1'b0, 1'b0);
        chk("bp_model_sum", 64'(e.sum), 64'h0100);
        send(16'h0042, 16'h0058, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (10) @(negedge clk);
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        or_force = 1'b1;
        @(posedge clk);
        #2 or_force = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_queue_drained", 64'(exp_q.size()), 64'd0);
        bp_mode = 0;

        // Asynchronous reset in the middle of RUN (digit index 2).
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        directed("post_rst_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef BCD_DIGIT_CHECK_EN
        e = model(16'h00A0, 16'h0000, 1'b0, 1'b0);
        chk("inv_model_err", 64'(e.err), 64'd1);
        send(16'h00A0, 16'h0000, 1'b0, 1'b0);
        wait_idle();
        directed("after_inv_add", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);
`endif

        // Random operations with random backpressure and idle gaps.
        bp_mode = 1;
        repeat (150) begin
            send(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        bp_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
